// File: rtl/fp_unpack_r4_pkg.sv
// fp_unpack_r4_pkg: shared FP constants, FSM state and FCLASS encoding
package fp_unpack_r4_pkg;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  localparam int unsigned BIAS = 127;
  localparam logic [7:0] EXP_MAX = 8'd255;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [3:0] CLS_NEG_INF = 4'd0;
  localparam logic [3:0] CLS_NEG_NORM = 4'd1;
  localparam logic [3:0] CLS_NEG_SUB = 4'd2;
  localparam logic [3:0] CLS_NEG_ZERO = 4'd3;
  localparam logic [3:0] CLS_POS_ZERO = 4'd4;
  localparam logic [3:0] CLS_POS_SUB = 4'd5;
  localparam logic [3:0] CLS_POS_NORM = 4'd6;
  localparam logic [3:0] CLS_POS_INF = 4'd7;
  localparam logic [3:0] CLS_SNAN = 4'd8;
  localparam logic [3:0] CLS_QNAN = 4'd9;
  function automatic logic [9:0] fclass(input logic [31:0] x);
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    logic [3:0] idx;
    s = x[31];
    e = x[30:23];
    f = x[22:0];
    idx = e == EXP_MAX ? (f == '0 ? (s ? CLS_NEG_INF : CLS_POS_INF) : (f[22] ? CLS_QNAN : CLS_SNAN)) :
          e == '0 ? (f == '0 ? (s ? CLS_NEG_ZERO : CLS_POS_ZERO) : (s ? CLS_NEG_SUB : CLS_POS_SUB)) :
          (s ? CLS_NEG_NORM : CLS_POS_NORM);
    return 10'd1 << idx;
  endfunction
endpackage

// File: rtl/fp_unpack_r4_if.sv
// fp_unpack_r4_if: operand-in / unpacked-result-out handshake bundle
interface fp_unpack_r4_if;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_data;
  logic out_valid;
  logic out_ready;
  logic out_sign;
  logic signed [9:0] out_exp;
  logic [23:0] out_mant;
  logic [9:0] out_class;
  logic out_is_zero;
  logic out_is_inf;
  logic out_is_nan;
  logic out_is_snan;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_sign, out_exp, out_mant, out_class,
    out_is_zero, out_is_inf, out_is_nan, out_is_snan
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_class,
    out_is_zero, out_is_inf, out_is_nan, out_is_snan
  );
endinterface

// File: rtl/fp_unpack_r4_norm_step.sv
// fp_norm_step_r4: one radix-4 normalization step (shift by 2, 1 or 0)
module fp_norm_step_r4 (
  input  logic [23:0]        mant,
  input  logic signed [9:0]  exp,
  output logic [23:0]        next_mant,
  output logic signed [9:0]  next_exp
);
  always_comb begin
    next_mant = ~|mant[23:22] ? mant << 2 : ~mant[23] ? mant << 1 : mant;
    next_exp = ~|mant[23:22] ? exp - 10'sd2 : ~mant[23] ? exp - 10'sd1 : exp;
  end
endmodule

// File: rtl/fp_unpack_r4.sv
// fp_unpack_r4: unpacks binary32 into sign/exp/explicit significand/FCLASS,
// normalizing subnormals two bits per cycle
module fp_unpack_r4
  import fp_unpack_r4_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  fp_unpack_r4_if.slave bus
);
  state_t state, state_n;
  logic live;
  logic sign, is_zero, is_inf, is_nan, is_snan;
  logic signed [9:0] exp;
  logic [23:0] mant;
  logic [9:0] cls;
  logic [23:0] step_mant;
  logic signed [9:0] step_exp;
  logic [7:0] exp_f;
  logic [22:0] frac;
  logic accept, sub, zero, top;
  assign exp_f = bus.in_data[30:23];
  assign frac = bus.in_data[22:0];
  assign accept = bus.in_valid & bus.in_ready;
  assign sub = exp_f == '0 && frac != '0;
  assign zero = exp_f == '0 && frac == '0;
  assign top = exp_f == EXP_MAX;
  fp_norm_step_r4 u_step (
    .mant      (mant),
    .exp       (exp),
    .next_mant (step_mant),
    .next_exp  (step_exp)
  );
  // live keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
    end else begin
      state <= state_n;
      live <= 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = sub ? NORM : DONE;
    else if (state == NORM && step_mant[23]) state_n = DONE;
    else if (state == DONE && bus.out_ready) state_n = IDLE;
  end
  always_comb begin
    bus.in_ready = live && state == IDLE;
    bus.out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      exp <= '0;
      mant <= '0;
      cls <= '0;
      is_zero <= 1'b0;
      is_inf <= 1'b0;
      is_nan <= 1'b0;
      is_snan <= 1'b0;
    end else if (accept) begin
      sign <= bus.in_data[31];
      exp <= sub ? 10'sd1 : zero ? 10'sd0 : $signed({2'b00, exp_f});
      mant <= sub ? {1'b0, frac} : zero ? 24'd0 : {1'b1, frac};
      cls <= fclass(bus.in_data);
      is_zero <= zero;
      is_inf <= top && frac == '0;
      is_nan <= top && frac != '0;
      is_snan <= top && frac != '0 && !frac[22];
    end else if (state == NORM) begin
      exp <= step_exp;
      mant <= step_mant;
    end
  end
  always_comb begin
    bus.out_sign = sign;
    bus.out_exp = exp;
    bus.out_mant = mant;
    bus.out_class = cls;
    bus.out_is_zero = is_zero;
    bus.out_is_inf = is_inf;
    bus.out_is_nan = is_nan;
    bus.out_is_snan = is_snan;
  end
endmodule

// File: tb/tb_fp_unpack_r4.sv
// tb_fp_unpack_r4: directed vectors plus hold and mid-normalization reset sequences
module tb_fp_unpack_r4;
  import fp_unpack_r4_pkg::*;
  typedef struct {
    logic [31:0] data;
    logic sign;
    logic signed [9:0] exp;
    logic [23:0] mant;
    logic [3:0] cls;
    logic [3:0] flags;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  vec_t vecs[14];
  fp_unpack_r4_if bus();
  fp_unpack_r4 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int lat;
    logic [9:0] one;
    one = 10'd1 << v.cls;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = v.data;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = 32'hFFFF_FFFF;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("lat %h", v.data), lat, v.lat);
    check($sformatf("sign %h", v.data), {31'd0, bus.out_sign}, {31'd0, v.sign});
    check($sformatf("exp %h", v.data), {22'd0, bus.out_exp}, {22'd0, v.exp});
    check($sformatf("mant %h", v.data), {8'd0, bus.out_mant}, {8'd0, v.mant});
    check($sformatf("class %h", v.data), {22'd0, bus.out_class}, {22'd0, one});
    check($sformatf("flags %h", v.data),
          {28'd0, bus.out_is_zero, bus.out_is_inf, bus.out_is_nan, bus.out_is_snan}, {28'd0, v.flags});
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check($sformatf("ready after %h", v.data), {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask
  initial begin
    logic [23:0] held_mant;
    logic [9:0] held_class;
    int lat;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    // flags = {zero, inf, nan, snan}
    vecs[0]  = '{32'h3F80_0000, 1'b0, 10'sd127, 24'h800000, 4'd6, 4'b0000, 1};
    vecs[1]  = '{32'h0000_0001, 1'b0, -10'sd22, 24'h800000, 4'd5, 4'b0000, 13};
    vecs[2]  = '{32'h8040_0000, 1'b1, 10'sd0,   24'h800000, 4'd2, 4'b0000, 2};
    vecs[3]  = '{32'h7F80_0001, 1'b0, 10'sd255, 24'h800001, 4'd8, 4'b0011, 1};
    vecs[4]  = '{32'h7FC0_0000, 1'b0, 10'sd255, 24'hC00000, 4'd9, 4'b0010, 1};
    vecs[5]  = '{32'hFF80_0000, 1'b1, 10'sd255, 24'h800000, 4'd0, 4'b0100, 1};
    vecs[6]  = '{32'h8000_0000, 1'b1, 10'sd0,   24'h000000, 4'd3, 4'b1000, 1};
    vecs[7]  = '{32'h0000_0000, 1'b0, 10'sd0,   24'h000000, 4'd4, 4'b1000, 1};
    vecs[8]  = '{32'hC049_0FDB, 1'b1, 10'sd128, 24'hC90FDB, 4'd1, 4'b0000, 1};
    vecs[9]  = '{32'h7F7F_FFFF, 1'b0, 10'sd254, 24'hFFFFFF, 4'd6, 4'b0000, 1};
    vecs[10] = '{32'h0040_0000, 1'b0, 10'sd0,   24'h800000, 4'd5, 4'b0000, 2};
    vecs[11] = '{32'h0020_0000, 1'b0, -10'sd1,  24'h800000, 4'd5, 4'b0000, 2};
    vecs[12] = '{32'h7F80_0000, 1'b0, 10'sd255, 24'h800000, 4'd7, 4'b0100, 1};
    vecs[13] = '{32'h0080_0000, 1'b0, 10'sd1,   24'h800000, 4'd6, 4'b0000, 1};
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset data", {bus.out_mant, 8'd0} | {22'd0, bus.out_class}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready after reset", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.in_data = 32'h3F80_0000;
    check("hold valid", {31'd0, bus.out_valid}, 32'd1);
    held_mant = bus.out_mant;
    held_class = bus.out_class;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold state", {bus.out_valid, bus.in_ready, 2'b00, bus.out_exp, held_mant == bus.out_mant,
            held_class == bus.out_class, 16'd0}, {1'b1, 1'b0, 2'b00, 10'sd128, 1'b1, 1'b1, 16'd0});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("second not accepted", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h0000_0001;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("norm in progress", {30'd0, bus.out_valid, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-norm reset state", {30'd0, dut.state}, {30'd0, IDLE});
    check("mid-norm reset out", {bus.out_valid, bus.in_ready, bus.out_exp, bus.out_class} | {8'd0, bus.out_mant}, 32'd0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      lat += bus.out_valid;
    end
    check("no output after reset", lat, 0);
    run_vec('{32'h4000_0000, 1'b0, 10'sd128, 24'h800000, 4'd6, 4'b0000, 1});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_unpack_r4.md
FP_UNPACK_R4 -- requirements
Module: fp_unpack_r4

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, operand offered.
REQ-004 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-005 SHALL have port in_data, input, 32, IEEE-754 binary32 operand.
REQ-006 SHALL have port out_valid, output, 1, unpacked result available.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-008 SHALL have port out_sign, output, 1, operand sign.
REQ-009 SHALL have port out_exp, output, 10, signed biased exponent after normalization.
REQ-010 SHALL have port out_mant, output, 24, significand with explicit leading bit.
REQ-011 SHALL have port out_class, output, 10, RISC-V FCLASS one-hot mask.
REQ-012 SHALL have ports out_is_zero, out_is_inf, out_is_nan and out_is_snan, each output, 1, special-case flags.

Function
REQ-013 SHALL implement FSM states IDLE, NORM and DONE.
REQ-014 SHALL drive in_ready high only in IDLE; an operand is accepted when in_valid and in_ready are both high.
REQ-015 On accept of a normal, zero, inf or NaN operand: SHALL go IDLE->DONE, giving 1-cycle latency to out_valid.
REQ-016 On accept of a subnormal operand (exp==0, frac!=0): SHALL go IDLE->NORM with mant={1'b0,frac} and exp=+1.
REQ-017 In NORM, each cycle: if mant[23:22]==00, mant shifts left 2 and exp decrements by 2; else if mant[23]==0, mant shifts left 1 and exp decrements by 1.
REQ-018 SHALL go NORM->DONE in the cycle mant[23] becomes 1.
REQ-019 Worst-case subnormal 0x00000001 SHALL finish with mant=0x800000 and exp=-22, in at most 12 NORM cycles.
REQ-020 Normal operand: SHALL give mant={1,frac} and exp={2'b00,exp_field}.
REQ-021 Zero operand: SHALL give mant=0 and exp=0.
REQ-022 Inf/NaN operand: SHALL give mant={1,frac} and exp=255.
REQ-023 SHALL flag a NaN as signalling when frac[22]==0 and as quiet otherwise.
REQ-024 out_class SHALL have exactly one bit set, with bits 0..9 = -inf, -normal, -subnormal, -0, +0, +subnormal, +normal, +inf, sNaN, qNaN.
REQ-025 out_class SHALL be computed from the raw input and registered at accept.
REQ-026 In DONE, out_valid SHALL be high and all out_* SHALL be held stable until out_ready is high.
REQ-027 DONE with out_ready high SHALL return to IDLE the next cycle; a new accept is then possible, giving a non-subnormal throughput of one operand per 2 cycles.
REQ-028 in_data SHALL be ignored when not accepted; changes in_data during NORM SHALL have no effect.
REQ-029 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-030 While rst_n is low, the state SHALL be IDLE.
REQ-031 While rst_n is low, out_valid SHALL be 0 and all out_* data and flags SHALL be 0.
REQ-032 While rst_n is low, in_ready SHALL be 0; in_ready SHALL be 1 from the first clock edge after deassertion.
REQ-033 Reset asserted mid-NORM or in DONE SHALL discard the operand immediately, with no partial output.

Structure
REQ-034 The shared FP package SHALL hold the FSM state enum, FCLASS bit-index constants, BIAS=127, EXP_MAX=255 and canonical NaN 0x7FC00000.
REQ-035 The radix-4 shift step (mant/exp in -> mant/exp out, combinational) SHALL be the sub-module fp_norm_step_r4.

Verification
REQ-036 Bench SHALL drive 0x3F800000 -> 1 cycle later: out_valid, sign 0, exp 127, mant 0x800000, class bit6.
REQ-037 Bench SHALL drive 0x00000001 -> after 12 NORM cycles: exp -22, mant 0x800000, class bit5.
REQ-038 Bench SHALL drive 0x80400000 -> 1 NORM cycle: exp 0, mant 0x800000, sign 1, class bit2.
REQ-039 Bench SHALL drive 0x7F800001 -> is_nan=1, is_snan=1, class bit8.
REQ-040 Bench SHALL drive 0x7FC00000 -> is_snan=0, class bit9.
REQ-041 Bench SHALL drive 0xFF800000 -> is_inf=1, class bit0.
REQ-042 Bench SHALL drive 0x80000000 -> is_zero=1, class bit3.
REQ-043 Bench SHALL hold out_ready low 5 cycles in DONE -> outputs stable, in_ready 0, and a second in_valid is not accepted.
REQ-044 Bench SHALL pulse rst_n low during NORM of 0x00000001 -> out_valid stays 0, state IDLE, and a following 0x40000000 gives exp 128.
